store_align: RTL and testbench

STORE_ALIGN -- requirements
Module: store_align

---
 rtl/isa_shared.sv | 37 +++
 rtl/store_lane_gen.sv | 32 +++
 rtl/store_align.sv | 177 +++++++++++++++++
 tb/tb_store_align.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_shared.sv
// ============================================================================
// Module      : isa_shared (package)
// Description : Store-size encoding and size-to-byte-mask constants shared by
//               the store alignment path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_shared;

  // Store size as encoded on the request interface; 2'b11 is illegal.
  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_H = 2'd1,
    ST_W = 2'd2
  } st_size_t;

  // Unshifted byte-lane masks for each legal size.
  localparam logic [3:0] MASK_B = 4'h1;
  localparam logic [3:0] MASK_H = 4'h3;
  localparam logic [3:0] MASK_W = 4'hF;

  // Byte mask for a size; an all-zero mask marks the illegal encoding.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = MASK_B;
      2'd1:    m = MASK_H;
      2'd2:    m = MASK_W;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_gen.sv
// ============================================================================
// Module      : store_lane_gen
// Description : Combinational lane shifter. Places a right-justified store
//               value and its byte mask at the byte offset within a 64-bit
//               (two-word) window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_gen
  import isa_shared::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  st_size_t    size_i,
  output logic [63:0] data_o,
  output logic [7:0]  mask_o
);

  logic [5:0] shamt;

  assign shamt = {1'b0, off_i, 3'b000};

  // Shift zero-extended data and size mask up to the addressed byte lane.
  always_comb begin
    data_o = {32'd0, data_i} << shamt;
    mask_o = {4'd0, size_mask(size_i)} << off_i;
  end

endmodule

`default_nettype wire

// File: rtl/store_align.sv
// ============================================================================
// Module      : store_align
// Description : Store alignment unit. Accepts a byte/half/word store with an
//               arbitrary byte address and issues one or two word-aligned
//               write beats with byte strobes, then pulses st_done or
//               st_fault.
//               Build option STORE_SPLIT_EN: when defined, stores that cross
//               a word boundary are split into two beats; otherwise they are
//               rejected with st_fault and no beat is issued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_align
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  st_size_t                req_size,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    st_done,
  output logic                    st_fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

`ifdef STORE_SPLIT_EN
  localparam int BEATS = 2;
`else
  localparam int BEATS = 1;
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [32*BEATS-1:0]   data_q;
  logic [4*BEATS-1:0]    mask_q;
  logic                  fault_q;

  logic [63:0]           lane_data;
  logic [7:0]            lane_mask;
  logic                  lane_crosses;
  logic                  size_illegal;
  logic                  accept;
  logic                  accept_fault;

  store_lane_gen u_lane_gen (
    .data_i (req_data[31:0]),
    .off_i  (req_addr[1:0]),
    .size_i (req_size),
    .data_o (lane_data),
    .mask_o (lane_mask)
  );

  assign lane_crosses = |lane_mask[7:4];
  assign size_illegal = (size_mask(req_size) == 4'h0);
  assign accept       = (state_q == S_IDLE) && req_valid;

`ifdef STORE_SPLIT_EN
  assign accept_fault = size_illegal;
`else
  // Upper lane data only matters when a second beat can be issued.
  logic unused_lane_hi;
  assign unused_lane_hi = ^lane_data[63:32];
  assign accept_fault   = size_illegal | lane_crosses;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the aligned request on acceptance; held stable for the whole store.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      data_q  <= lane_data[32*BEATS-1:0];
      mask_q  <= lane_mask[4*BEATS-1:0];
      fault_q <= accept_fault;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = accept_fault ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (mem_ready) begin
`ifdef STORE_SPLIT_EN
          state_d = (|mask_q[7:4]) ? S_BEAT1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
      S_BEAT1: begin
`ifdef STORE_SPLIT_EN
        if (mem_ready) begin
          state_d = S_RESP;
        end
`else
        // Unreachable without splitting; recover to idle.
        state_d = S_IDLE;
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and latched request.
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    st_done   = 1'b0;
    st_fault  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q[31:0];
        mem_wstrb = mask_q[3:0];
      end
`ifdef STORE_SPLIT_EN
      S_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q + ADDR_WIDTH'(4);
        mem_wdata = data_q[63:32];
        mem_wstrb = mask_q[7:4];
      end
`endif
      S_RESP: begin
        st_done  = ~fault_q;
        st_fault = fault_q;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_store_align.sv
// ============================================================================
// Module      : tb_store_align
// Description : Self-checking bench for store_align: table of stores with a
//               beat/response scoreboard under random backpressure, plus
//               hand-written latency, stall, illegal-size and reset sequences.
//               Expectations follow STORE_SPLIT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_align;
  import isa_shared::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  st_size_t    req_size = ST_B;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        st_done;
  logic        st_fault;

  logic        ready_ctl = 1'b1;
  logic        rnd_en = 1'b0;
  logic        rnd_bit = 1'b1;
  logic        sb_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_ready = rnd_en ? rnd_bit : ready_ctl;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  store_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .st_done   (st_done),
    .st_fault  (st_fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          nb;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
    bit          fault;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_beats[$];
  bit    exp_resp[$];
  vec_t  vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size, input int nb,
                              input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
                              input bit fault);
    vec_t v;
    v.addr = addr; v.data = data; v.size = size; v.nb = nb;
    v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.fault = fault;
    return v;
  endfunction

  // Scoreboard: compare each completed beat and each response pulse.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      chk("done_fault_exclusive", {63'd0, st_done & st_fault}, 64'd0);
      if (mem_valid && mem_ready) begin
        chk("beat_expected", {63'd0, exp_beats.size() != 0}, 64'd1);
        if (exp_beats.size() != 0) begin
          beat_t b;
          b = exp_beats.pop_front();
          chk("beat_addr", {32'd0, mem_addr}, {32'd0, b.addr});
          chk("beat_wdata", {32'd0, mem_wdata}, {32'd0, b.data});
          chk("beat_wstrb", {60'd0, mem_wstrb}, {60'd0, b.strb});
        end
      end
      if (st_done || st_fault) begin
        chk("resp_expected", {63'd0, exp_resp.size() != 0}, 64'd1);
        chk("beats_before_resp", 64'(exp_beats.size()), 64'd0);
        if (exp_resp.size() != 0) begin
          bit f;
          f = exp_resp.pop_front();
          chk("resp_fault", {63'd0, st_fault}, {63'd0, f});
        end
      end
    end
  end

  // Present one request in an idle cycle; returns one edge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = st_size_t'(s);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
    chk({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_mem_wstrb"}, {60'd0, mem_wstrb}, 64'd0);
    chk({tag, "_st_done"}, {63'd0, st_done}, 64'd0);
    chk({tag, "_st_fault"}, {63'd0, st_fault}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'h1000, 32'hDEADBEEF, 2'd2, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    vecs[1]  = mk(32'h2003, 32'h000000A5, 2'd0, 1, 32'h2000, 32'hA5000000, 4'h8, 0, 0, 0, 0);
`ifdef STORE_SPLIT_EN
    vecs[2]  = mk(32'h3002, 32'h11223344, 2'd2, 2, 32'h3000, 32'h33440000, 4'hC,
                  32'h3004, 32'h00001122, 4'h3, 0);
    vecs[8]  = mk(32'h9003, 32'h00001234, 2'd1, 2, 32'h9000, 32'h34000000, 4'h8,
                  32'h9004, 32'h00000012, 4'h1, 0);
    vecs[9]  = mk(32'hA001, 32'hAABBCCDD, 2'd2, 2, 32'hA000, 32'hBBCCDD00, 4'hE,
                  32'hA004, 32'h000000AA, 4'h1, 0);
`else
    vecs[2]  = mk(32'h3002, 32'h11223344, 2'd2, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(32'h9003, 32'h00001234, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(32'hA001, 32'hAABBCCDD, 2'd2, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    vecs[3]  = mk(32'h4000, 32'hCAFE1234, 2'd1, 1, 32'h4000, 32'hCAFE1234, 4'h3, 0, 0, 0, 0);
    vecs[4]  = mk(32'h5002, 32'h0000BEEF, 2'd1, 1, 32'h5000, 32'hBEEF0000, 4'hC, 0, 0, 0, 0);
    vecs[5]  = mk(32'h6001, 32'h00000077, 2'd0, 1, 32'h6000, 32'h00007700, 4'h2, 0, 0, 0, 0);
    vecs[6]  = mk(32'h7000, 32'h12345678, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(32'h8001, 32'h0000ABCD, 2'd1, 1, 32'h8000, 32'h00ABCD00, 4'h6, 0, 0, 0, 0);
    vecs[10] = mk(32'hB000, 32'h123456FF, 2'd0, 1, 32'hB000, 32'h123456FF, 4'h1, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of stores under random backpressure, checked by the scoreboard.
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].nb >= 1) exp_beats.push_back('{vecs[i].a0, vecs[i].d0, vecs[i].s0});
      if (vecs[i].nb == 2) exp_beats.push_back('{vecs[i].a1, vecs[i].d1, vecs[i].s1});
      exp_resp.push_back(vecs[i].fault);
      send(vecs[i].addr, vecs[i].data, vecs[i].size);
      for (int c = 0; c < 60 && exp_resp.size() != 0; c++) @(negedge clk);
      chk("resp_timeout", 64'(exp_resp.size()), 64'd0);
    end
    @(negedge clk);
    rnd_en = 1'b0;
    sb_en  = 1'b0;
    ready_ctl = 1'b1;

    // Latency: aligned word, memory always ready.
    send(32'h1000, 32'hDEADBEEF, 2'd2);
    @(negedge clk);
    chk("lat_n1_valid", {63'd0, mem_valid}, 64'd1);
    chk("lat_n1_addr", {32'd0, mem_addr}, 64'h1000);
    chk("lat_n1_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    chk("lat_n1_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("lat_n2_done", {63'd0, st_done}, 64'd1);
    chk("lat_n2_valid", {63'd0, mem_valid}, 64'd0);
    chk("lat_n2_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("lat_n3_ready", {63'd0, req_ready}, 64'd1);
    chk("lat_n3_done", {63'd0, st_done}, 64'd0);

    // Stall: memory not ready for three cycles; beat must hold steady.
    ready_ctl = 1'b0;
    send(32'h4000, 32'hCAFE1234, 2'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, mem_valid}, 64'd1);
      chk("stall_addr", {32'd0, mem_addr}, 64'h4000);
      chk("stall_wdata", {32'd0, mem_wdata}, 64'hCAFE1234);
      chk("stall_wstrb", {60'd0, mem_wstrb}, 64'h3);
      chk("stall_done", {63'd0, st_done}, 64'd0);
    end
    @(posedge clk); #1;
    ready_ctl = 1'b1;
    @(negedge clk);
    chk("stall_last_valid", {63'd0, mem_valid}, 64'd1);
    @(negedge clk);
    chk("stall_done_after", {63'd0, st_done}, 64'd1);

    // Illegal size.
    send(32'h7000, 32'h0, 2'd3);
    @(negedge clk);
    chk("illegal_valid", {63'd0, mem_valid}, 64'd0);
    chk("illegal_fault", {63'd0, st_fault}, 64'd1);
    chk("illegal_done", {63'd0, st_done}, 64'd0);
    chk("illegal_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("illegal_ready_back", {63'd0, req_ready}, 64'd1);
    chk("illegal_fault_gone", {63'd0, st_fault}, 64'd0);

    // Top-of-address-space halfword; reset while the second beat is pending.
    send(32'hFFFFFFFF, 32'h0000ABCD, 2'd1);
    @(negedge clk);
`ifdef STORE_SPLIT_EN
    chk("wrap_b0_addr", {32'd0, mem_addr}, 64'hFFFFFFFC);
    chk("wrap_b0_wdata", {32'd0, mem_wdata}, 64'hCD000000);
    chk("wrap_b0_wstrb", {60'd0, mem_wstrb}, 64'h8);
    @(posedge clk); #1;
    ready_ctl = 1'b0;
    @(negedge clk);
    chk("wrap_b1_valid", {63'd0, mem_valid}, 64'd1);
    chk("wrap_b1_addr", {32'd0, mem_addr}, 64'h0);
    chk("wrap_b1_wdata", {32'd0, mem_wdata}, 64'h000000AB);
    chk("wrap_b1_wstrb", {60'd0, mem_wstrb}, 64'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_beat1");
    @(negedge clk);
    chk("rst_beat1_no_done", {63'd0, st_done}, 64'd0);
    chk("rst_beat1_no_valid", {63'd0, mem_valid}, 64'd0);
`else
    chk("wrap_nosplit_valid", {63'd0, mem_valid}, 64'd0);
    chk("wrap_nosplit_fault", {63'd0, st_fault}, 64'd1);
    @(negedge clk);
    chk("wrap_nosplit_ready", {63'd0, req_ready}, 64'd1);
`endif
    ready_ctl = 1'b1;

    // Reset while the first beat is stalled.
    ready_ctl = 1'b0;
    send(32'hC000, 32'h55AA55AA, 2'd2);
    @(negedge clk);
    chk("rst_b0_valid", {63'd0, mem_valid}, 64'd1);
    chk("rst_b0_addr", {32'd0, mem_addr}, 64'hC000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_beat0");
    @(negedge clk);
    chk("rst_beat0_no_done", {63'd0, st_done}, 64'd0);
    ready_ctl = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
